fp_int2fp: RTL and testbench

Sequential converter from 32-bit two's-complement integers to the team's custom 32-bit floating-point format: sign [31], 6-bit exponent [30:25] with bias 31, 25-bit fraction [24:0] with implicit leading 1. It sits in front of the FPU adder and produces its `op_A_in` / `op_B_in` operands from integer sources. Normalisation is iterative, one bit per cycle. Input and output use valid/ready handshakes.

---
 rtl/fp_int2fp.sv | 108 ++++++++++
 tb/tb_fp_int2fp.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_int2fp.sv
// Iterative int32 -> custom float (sign, 6-bit exp bias BIAS, 25-bit frac), one normalise shift per cycle.
// Define FP_INT2FP_ROUND_EN for round-to-nearest-even; otherwise the fraction is truncated.
module fp_int2fp #(
  parameter int BIAS = 31
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] int_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] data_out,
  output logic [3:0]  status_out
);

  typedef enum logic [2:0] {IDLE, ABS, NORM, ROUND, DONE} state_t;

  localparam logic [5:0] BIAS_F = 6'(BIAS);

  state_t      state;
  logic        sign;
  logic [31:0] mag;
  logic [5:0]  e;

  logic [24:0] frac;
  logic        guard;
  logic        sticky;
  logic        inexact;
  logic        round_up;
  logic [24:0] frac_rnd;
  logic [5:0]  e_rnd;

  assign in_ready = (state == IDLE);

  assign frac    = mag[30:6];
  assign guard   = mag[5];
  assign sticky  = |mag[4:0];
  assign inexact = guard | sticky;

`ifdef FP_INT2FP_ROUND_EN
  logic [25:0] frac_sum;
  assign round_up = guard & (sticky | frac[0]);
  assign frac_sum = {1'b0, frac} + {25'd0, round_up};
  // A carry out leaves the low 25 bits at zero, so only the exponent needs fixing.
  assign frac_rnd = frac_sum[24:0];
  assign e_rnd    = e + {5'd0, frac_sum[25]};
`else
  assign round_up = 1'b0;
  assign frac_rnd = frac;
  assign e_rnd    = e;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      data_out   <= 32'd0;
      status_out <= 4'd0;
      sign       <= 1'b0;
      mag        <= 32'd0;
      e          <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mag   <= int_in;
            state <= ABS;
          end
        end
        ABS: begin
          sign  <= mag[31];
          mag   <= mag[31] ? -mag : mag;
          e     <= 6'd31;
          // Zero bypasses normalisation but still spends a cycle in ROUND.
          state <= (mag == 32'd0) ? ROUND : NORM;
        end
        NORM: begin
          if (mag[31]) begin
            state <= ROUND;
          end else begin
            mag <= mag << 1;
            e   <= e - 6'd1;
          end
        end
        ROUND: begin
          out_valid <= 1'b1;
          state     <= DONE;
          if (mag == 32'd0) begin
            data_out   <= 32'd0;
            status_out <= 4'b0001;
          end else begin
            data_out   <= {sign, e_rnd + BIAS_F, frac_rnd};
            status_out <= {round_up, inexact, sign, 1'b0};
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_int2fp.sv
// Randomised scoreboard bench for fp_int2fp: arithmetic reference model, latency, backpressure and reset checks.
module tb_fp_int2fp;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] int_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic [3:0]  status_out;

  fp_int2fp #(.BIAS(31)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .int_in(int_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .status_out(status_out)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  status;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   mode = 0;   // 0 random out_ready, 1 held low, 2 held high
  bit   prev_v = 0;

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  always begin
    @(posedge clock);
    #2;
    case (mode)
      1:       out_ready = 1'b0;
      2:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, req, $time);
    end
  endtask

  // Value-level model: magnitude, MSB position, fraction and remainder by integer arithmetic.
  function automatic exp_t model(input logic [31:0] x);
    exp_t   r;
    longint sv, m, one, num, q, rem, half;
    int     p;
    bit     neg, up, inx;
    one = 1;
    sv  = longint'($signed(x));
    neg = (sv < 0);
    m   = neg ? -sv : sv;
    if (m == 0) begin
      r.data = 32'd0; r.status = 4'b0001; r.lat = 2;
      return r;
    end
    p = 0;
    for (int i = 0; i < 32; i++) if (m >= (one << i)) p = i;
    r.lat = 34 - p;
    num = (m - (one << p)) << 25;
    q   = num >> p;
    rem = num - (q << p);
    inx = (rem != 0);
    up  = 0;
`ifdef FP_INT2FP_ROUND_EN
    if (p > 0) begin
      half = one << (p - 1);
      up = (rem > half) || ((rem == half) && q[0]);
    end
`endif
    if (up) q = q + 1;
    if (q == (one << 25)) begin
      q = 0;
      p = p + 1;
    end
    r.data   = {neg, 6'(p + 31), 25'(q)};
    r.status = {up, inx, neg, 1'b0};
    return r;
  endfunction

  task automatic send(input logic [31:0] x, input bit expect_out);
    int   n = 0;
    exp_t ex;
    @(negedge clock);
    while (!in_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout actual=busy required=in_ready");
    end else begin
      in_valid = 1'b1;
      int_in   = x;
      if (expect_out) begin
        ex = model(x);
        ex.lat = cyc + 1 + ex.lat;   // absolute edge at which out_valid must first be seen
        sb.push_back(ex);
      end
      @(negedge clock);
      in_valid = 1'b0;
      int_in   = $urandom;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  always @(negedge clock) begin
    exp_t ex;
    if (!reset) begin
      prev_v = 0;
    end else begin
      if (out_valid && !prev_v) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_output actual=%h required=none", data_out);
        end else begin
          ex = sb.pop_front();
          chk("data_out", data_out, ex.data);
          chk("status_out", 32'(status_out), 32'(ex.status));
          chk("latency_edge", cyc, ex.lat);
        end
      end
      prev_v = out_valid;
    end
  end

  logic [31:0] directed [8] = '{32'd1, 32'hFFFFFFFE, 32'd0, 32'h80000000,
                                32'h7FFFFFFF, 32'h04000001, 32'h04000003, 32'd3};

  initial begin
    exp_t        bp_ex;
    logic [31:0] x;
    int          n;
    reset = 1'b0; in_valid = 1'b0; int_in = 32'd0; out_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_data_out", data_out, 0);
    chk("reset_status_out", 32'(status_out), 0);
    chk("reset_in_ready", 32'(in_ready), 1);
    reset = 1'b1;

    foreach (directed[i]) send(directed[i], 1'b1);
    for (int i = 0; i < 40; i++) begin
      x = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) x = -x;
      send(x, 1'b1);
    end
    drain();

    // Backpressure: out_ready held low for 10 cycles while an extra request is offered.
    mode = 1;
    repeat (2) @(negedge clock);
    x = 32'h7FFFFFFF;
    bp_ex = model(x);
    send(x, 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_data_hold", data_out, bp_ex.data);
      chk("bp_status_hold", 32'(status_out), 32'(bp_ex.status));
      chk("bp_in_ready", 32'(in_ready), 0);
      in_valid = 1'b1;
      int_in   = $urandom;
      @(negedge clock);
    end
    in_valid = 1'b0;
    mode = 2;
    @(negedge clock);
    chk("release_still_done", 32'(in_ready), 0);
    @(negedge clock);
    chk("release_idle_ready", 32'(in_ready), 1);
    chk("release_valid_low", 32'(out_valid), 0);
    chk("release_data_kept", data_out, bp_ex.data);
    send(32'h04000003, 1'b1);
    drain();

    // Reset in the middle of normalisation discards the operand.
    send(32'd3, 1'b0);
    repeat (5) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("midreset_out_valid", 32'(out_valid), 0);
    chk("midreset_data_out", data_out, 0);
    chk("midreset_status_out", 32'(status_out), 0);
    chk("midreset_in_ready", 32'(in_ready), 1);
    @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    mode = 0;
    send(32'd3, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
